bitmap_line_fetcher: RTL and testbench
======================================

Name: bitmap_line_fetcher

Overview:
Successor to the combinational-address scanout path. It prefetches one scanline of bitmap pixels (GBA modes 3, 4 and 5, with page select and forced blank) from VRAM into a ping-pong line buffer. The VGA side reads finished 15-bit colours at a fixed 1-cycle latency. It sits between the VRAM/palette read ports and the vgac controller, and decouples VRAM latency from pixel timing.

Parameters:
H_PIXELS, 240, visible pixels per line (line buffer depth)
V_PIXELS, 160, visible lines; line_y >= V_PIXELS produces a backdrop-only line
COLOR_W, 15, BGR555 colour width
ADDR_W, 16, VRAM halfword address width
PAGE_OFFSET, 16'h5000, halfword offset of page 1 (modes 4/5)
M5_W, 160, mode-5 bitmap width
M5_H, 128, mode-5 bitmap height

Ports:
clk  in  1  system/pixel clock
rst_n  in  1  asynchronous active-low reset
dispcnt  in  16  display control; [2:0] mode, [4] page, [7] forced blank
line_start  in  1  one-cycle pulse: begin fetching line line_y, swap buffers
line_y  in  8  line number to fetch; sampled with line_start
vram_req  out  1  VRAM read request; held until vram_ack
vram_addr  out  ADDR_W  halfword address; stable while vram_req
vram_ack  in  1  vram_rdata valid this cycle; ends the request
vram_rdata  in  16  VRAM read data
pal_addr  out  8  palette index; pal_rdata valid the next cycle
pal_rdata  in  16  palette data
pix_x  in  $clog2(H_PIXELS)  display-side read column
pix_color  out  COLOR_W  colour at pix_x from the display bank, 1-cycle latency
busy  out  1  fill in progress
overrun  out  1  sticky; line_start arrived while busy; cleared only by reset

Behaviour:
- Reset: FSM IDLE; vram_req=0, vram_addr=0, pal_addr=0, pix_color=0, busy=0, overrun=0, display bank=0. Buffer contents are don't-care.
- On line_start: latch dispcnt and line_y; swap the fill and display banks; enter START. dispcnt changes mid-fill are ignored.
- Line_start while busy: abort the current fill (drop any outstanding vram_req the next cycle), set overrun, swap banks, restart. The partially filled bank is displayed as-is.
- FSM: IDLE -> START -> (BLANK | FETCH) ... -> IDLE.
  - BLANK path, taken when forced blank, line_y>=V_PIXELS, or mode not in {3,4,5}: first reads pal[0] for the backdrop (forced blank instead uses 15'h7FFF), then writes one pixel per cycle for H_PIXELS cycles.
  - FETCH: assert vram_req with an address; on vram_ack capture the data and go to STORE.
- Address generation (x = pixel column, y = line_y):
  - mode 3: y*240 + x
  - mode 4: page*PAGE_OFFSET + (y*240 + x)>>1. One halfword yields pixel x (low byte) and x+1 (high byte).
  - mode 5: page*PAGE_OFFSET + y*M5_W + x
  - Use incrementing row base and column counters; no multipliers.
- STORE:
  - mode 3: write vram_rdata[14:0] directly.
  - mode 5: same as mode 3; columns x>=M5_W, or y>=M5_H, take the backdrop and issue no VRAM read.
  - mode 4: a palette lookup per byte (2 cycles each: PAL_A, PAL_B); index 0 writes the backdrop (pal[0]), not the looked-up colour.
- Fill finishes after column H_PIXELS-1 is written; busy drops the same cycle the FSM returns to IDLE.
- Display port: pix_color <= display_bank[pix_x] every cycle. pix_x >= H_PIXELS returns 0.
- Widths: address arithmetic is truncated to ADDR_W; no wrap checks are needed because the maximum is < 2^16.

Decomposition:
- Shared package gfx_pkg: mode encodings (MODE3/4/5), FSM state enum, BGR555 constants (WHITE=15'h7FFF), default geometry constants.
- One sub-module: line_buffer_pp — dual-bank H_PIXELS x COLOR_W RAM with one write port (fill bank) and one registered read port (display bank), plus a bank-select toggle input.

Test Plan:
- Mode 3, line_y=5, VRAM model returns addr as data with 0-3 cycle random ack delay -> after fill, pix_x=0 gives 15'(1200), pix_x=239 gives 15'(1439); first vram_addr=1200.
- Mode 4, page=1, line_y=0, vram[0x5000]=16'h0201, pal[1]=15'h001F, pal[2]=15'h03E0 -> pix 0 = 15'h001F, pix 1 = 15'h03E0; first vram_addr=16'h5000.
- Mode 5, line_y=130 -> no vram_req at all; every pixel = pal[0]. Mode 5 with line_y=0 -> exactly 160 VRAM reads, and pixels 160..239 = pal[0].
- Forced blank (dispcnt=16'h0083) -> no VRAM or palette reads; all 240 pixels = 15'h7FFF.
- line_start pulsed again 50 cycles into a mode-3 fill -> overrun=1 and stays 1; vram_req drops within 1 cycle, then the new line fills correctly.
- rst_n asserted mid-fill with vram_req high -> vram_req, busy, pix_color = 0 immediately; after release, a normal line_start fill completes correctly.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared definitions for the bitmap scanout path: mode encodings, colours,
// default geometry and the line fetcher state encoding.
package gfx_pkg;

  localparam logic [2:0] Mode3 = 3'd3;
  localparam logic [2:0] Mode4 = 3'd4;
  localparam logic [2:0] Mode5 = 3'd5;

  localparam logic [14:0] White = 15'h7FFF;

  localparam int unsigned DefHPixels    = 240;
  localparam int unsigned DefVPixels    = 160;
  localparam int unsigned DefColorW     = 15;
  localparam int unsigned DefAddrW      = 16;
  localparam int unsigned DefM5W        = 160;
  localparam int unsigned DefM5H        = 128;
  localparam logic [15:0] DefPageOffset = 16'h5000;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StBdAddr,
    StBdData,
    StBlank,
    StFetch,
    StStore,
    StPalA,
    StPalB
  } fetch_state_e;

endpackage

// File: rtl/line_buffer_pp.sv
// Ping-pong scanline buffer: one bank is written by the fetcher while the
// other is read by the display; swap exchanges their roles.
module line_buffer_pp #(
  parameter int unsigned Depth = 240,
  parameter int unsigned Width = 15,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             swap,
  input  logic             wr_en,
  input  logic [AddrW-1:0] wr_addr,
  input  logic [Width-1:0] wr_data,
  input  logic [AddrW-1:0] rd_addr,
  output logic [Width-1:0] rd_data
);

  logic [Width-1:0] mem0 [Depth];
  logic [Width-1:0] mem1 [Depth];
  logic             bank_q;
  logic [Width-1:0] rd_data_q;
  logic             rd_in_range;

  assign rd_in_range = 32'(rd_addr) < Depth;
  assign rd_data     = rd_data_q;

  // bank_q names the display bank; the fill bank is its complement.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (bank_q) begin
        mem0[wr_addr] <= wr_data;
      end else begin
        mem1[wr_addr] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      if (swap) begin
        bank_q <= ~bank_q;
      end
      if (!rd_in_range) begin
        rd_data_q <= '0;
      end else if (bank_q) begin
        rd_data_q <= mem1[rd_addr];
      end else begin
        rd_data_q <= mem0[rd_addr];
      end
    end
  end

endmodule

// File: rtl/bitmap_line_fetcher.sv
// Prefetches one bitmap scanline (modes 3/4/5) from VRAM into a ping-pong
// line buffer; the display reads finished colours with one cycle of latency.
module bitmap_line_fetcher
  import gfx_pkg::*;
#(
  parameter int unsigned H_PIXELS    = DefHPixels,
  parameter int unsigned V_PIXELS    = DefVPixels,
  parameter int unsigned COLOR_W     = DefColorW,
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter logic [15:0] PAGE_OFFSET = DefPageOffset,
  parameter int unsigned M5_W        = DefM5W,
  parameter int unsigned M5_H        = DefM5H
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [15:0]                 dispcnt,
  input  logic                        line_start,
  input  logic [7:0]                  line_y,
  output logic                        vram_req,
  output logic [ADDR_W-1:0]           vram_addr,
  input  logic                        vram_ack,
  input  logic [15:0]                 vram_rdata,
  output logic [7:0]                  pal_addr,
  input  logic [15:0]                 pal_rdata,
  input  logic [$clog2(H_PIXELS)-1:0] pix_x,
  output logic [COLOR_W-1:0]          pix_color,
  output logic                        busy,
  output logic                        overrun
);

  localparam int unsigned   XW      = $clog2(H_PIXELS);
  localparam logic [XW-1:0] LastCol = XW'(H_PIXELS - 1);
  localparam logic [XW-1:0] M5Col   = XW'(M5_W);
  localparam logic [7:0]    VLimit  = 8'(V_PIXELS);
  localparam logic [7:0]    M5Rows  = 8'(M5_H);

  fetch_state_e        state_q;
  logic [2:0]          mode_q;
  logic                page_q;
  logic                fblank_q;
  logic [7:0]          y_q;
  logic [XW-1:0]       col_q;
  logic [ADDR_W-1:0]   vram_addr_q;
  logic                vram_req_q;
  logic [7:0]          pal_addr_q;
  logic [COLOR_W-1:0]  backdrop_q;
  logic [15:0]         data_q;
  logic                hi_byte_q;
  logic                blank_path_q;
  logic                overrun_q;
  logic                wr_en_q;
  logic [XW-1:0]       wr_addr_q;
  logic [COLOR_W-1:0]  wr_data_q;

  logic [ADDR_W-1:0]   y_w;
  logic [ADDR_W-1:0]   page_base;
  logic [ADDR_W-1:0]   row_base;
  logic                blank_line;
  logic [XW-1:0]       col_nx;
  logic                last_col;
  logic                pix_wr;
  logic                pix_adv;
  logic [COLOR_W-1:0]  pix_val;
  logic                unused_bits;

  assign vram_req  = vram_req_q;
  assign vram_addr = vram_addr_q;
  assign pal_addr  = pal_addr_q;
  assign busy      = (state_q != StIdle);
  assign overrun   = overrun_q;
  assign col_nx    = col_q + XW'(1);
  assign last_col  = (col_q == LastCol);

  assign unused_bits = ^{dispcnt[15:8], dispcnt[6:5], dispcnt[3], pal_rdata[15]};

  // Row strides are fixed shift-add forms: 240 px (mode 3), 120 halfwords (mode 4), 160 px (mode 5).
  always_comb begin
    y_w       = ADDR_W'(y_q);
    page_base = page_q ? ADDR_W'(PAGE_OFFSET) : '0;
    unique case (mode_q)
      Mode4:   row_base = page_base + (y_w << 7) - (y_w << 3);
      Mode5:   row_base = page_base + (y_w << 7) + (y_w << 5);
      default: row_base = (y_w << 8) - (y_w << 4);
    endcase
    blank_line = fblank_q || (y_q >= VLimit) || !(mode_q inside {Mode3, Mode4, Mode5}) ||
                 ((mode_q == Mode5) && (y_q >= M5Rows));
  end

  always_comb begin
    pix_wr  = 1'b0;
    pix_adv = 1'b0;
    pix_val = backdrop_q;
    unique case (state_q)
      StBlank: begin
        pix_wr  = 1'b1;
        pix_adv = 1'b1;
      end
      StFetch: begin
        // Mode-5 columns past the bitmap edge take the backdrop without a read.
        if (!vram_req_q) begin
          pix_wr  = 1'b1;
          pix_adv = 1'b1;
        end
      end
      StStore: begin
        pix_wr  = 1'b1;
        pix_adv = 1'b1;
        pix_val = data_q[COLOR_W-1:0];
      end
      StPalB: begin
        pix_wr  = 1'b1;
        pix_adv = hi_byte_q;
        pix_val = (pal_addr_q == 8'd0) ? backdrop_q : pal_rdata[COLOR_W-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mode_q       <= '0;
      page_q       <= 1'b0;
      fblank_q     <= 1'b0;
      y_q          <= '0;
      col_q        <= '0;
      vram_addr_q  <= '0;
      vram_req_q   <= 1'b0;
      pal_addr_q   <= '0;
      backdrop_q   <= '0;
      data_q       <= '0;
      hi_byte_q    <= 1'b0;
      blank_path_q <= 1'b0;
      overrun_q    <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      wr_en_q   <= pix_wr;
      wr_addr_q <= col_q;
      wr_data_q <= pix_val;
      if (line_start) begin
        mode_q     <= dispcnt[2:0];
        page_q     <= dispcnt[4];
        fblank_q   <= dispcnt[7];
        y_q        <= line_y;
        vram_req_q <= 1'b0;
        state_q    <= StStart;
        if (busy) begin
          overrun_q <= 1'b1;
        end
      end else begin
        unique case (state_q)
          StStart: begin
            col_q        <= '0;
            vram_addr_q  <= row_base;
            blank_path_q <= blank_line;
            if (fblank_q) begin
              backdrop_q <= COLOR_W'(White);
              state_q    <= StBlank;
            end else begin
              pal_addr_q <= 8'd0;
              state_q    <= StBdAddr;
            end
          end
          StBdAddr: state_q <= StBdData;
          StBdData: begin
            backdrop_q <= pal_rdata[COLOR_W-1:0];
            if (blank_path_q) begin
              state_q <= StBlank;
            end else begin
              state_q    <= StFetch;
              vram_req_q <= 1'b1;
            end
          end
          StFetch: begin
            if (vram_req_q && vram_ack) begin
              vram_req_q <= 1'b0;
              data_q     <= vram_rdata;
              if (mode_q == Mode4) begin
                pal_addr_q <= vram_rdata[7:0];
                hi_byte_q  <= 1'b0;
                state_q    <= StPalA;
              end else begin
                state_q <= StStore;
              end
            end
          end
          StPalA: state_q <= StPalB;
          StPalB: begin
            if (!hi_byte_q) begin
              pal_addr_q <= data_q[15:8];
              hi_byte_q  <= 1'b1;
              col_q      <= col_nx;
              state_q    <= StPalA;
            end
          end
          default: ;
        endcase
        if (pix_adv) begin
          if (last_col) begin
            state_q <= StIdle;
          end else begin
            col_q <= col_nx;
            if (state_q != StBlank) begin
              state_q     <= StFetch;
              vram_addr_q <= vram_addr_q + ADDR_W'(1);
              vram_req_q  <= !((mode_q == Mode5) && (col_nx >= M5Col));
            end
          end
        end
      end
    end
  end

  line_buffer_pp #(
    .Depth(H_PIXELS),
    .Width(COLOR_W),
    .AddrW(XW)
  ) u_line_buffer (
    .clk    (clk),
    .rst_n  (rst_n),
    .swap   (line_start),
    .wr_en  (wr_en_q),
    .wr_addr(wr_addr_q),
    .wr_data(wr_data_q),
    .rd_addr(pix_x),
    .rd_data(pix_color)
  );

endmodule

// File: tb/tb_bitmap_line_fetcher.sv
// Directed bench for bitmap_line_fetcher with small VRAM and palette models.
module tb_bitmap_line_fetcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] dispcnt;
  logic        line_start;
  logic [7:0]  line_y;
  logic        vram_req;
  logic [15:0] vram_addr;
  logic        vram_ack = 1'b0;
  logic [15:0] vram_rdata = 16'h0;
  logic [7:0]  pal_addr;
  logic [15:0] pal_rdata = 16'h0;
  logic [7:0]  pix_x;
  logic [14:0] pix_color;
  logic        busy;
  logic        overrun;

  int n_chk = 0;
  int n_err = 0;
  int acks = 0;
  int req_cycles = 0;
  int dly = 0;
  int a0;

  always #5 clk = ~clk;

  bitmap_line_fetcher u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dispcnt   (dispcnt),
    .line_start(line_start),
    .line_y    (line_y),
    .vram_req  (vram_req),
    .vram_addr (vram_addr),
    .vram_ack  (vram_ack),
    .vram_rdata(vram_rdata),
    .pal_addr  (pal_addr),
    .pal_rdata (pal_rdata),
    .pix_x     (pix_x),
    .pix_color (pix_color),
    .busy      (busy),
    .overrun   (overrun)
  );

  function automatic logic [15:0] vram_model(input logic [15:0] a);
    case (a)
      16'h5000: return 16'h0201;
      16'h5002: return 16'h0300;
      default:  return a;
    endcase
  endfunction

  function automatic logic [15:0] pal_model(input logic [7:0] i);
    case (i)
      8'd0:    return 16'h1234;
      8'd1:    return 16'h001F;
      8'd2:    return 16'h03E0;
      default: return {8'h40, i};
    endcase
  endfunction

  always @(posedge clk) pal_rdata <= pal_model(pal_addr);

  // VRAM answers each request after 0-3 idle cycles.
  always @(posedge clk) begin
    vram_ack <= 1'b0;
    if (vram_req && !vram_ack) begin
      if (dly == 0) begin
        vram_ack   <= 1'b1;
        vram_rdata <= vram_model(vram_addr);
        dly        <= $urandom_range(0, 3);
      end else begin
        dly <= dly - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (vram_req) req_cycles <= req_cycles + 1;
    if (vram_req && vram_ack) acks <= acks + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_line(input logic [15:0] dc, input logic [7:0] y);
    @(negedge clk);
    dispcnt    = dc;
    line_y     = y;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!vram_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, vram_req, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, 0);
  endtask

  task automatic expect_pix(input string tag, input logic [7:0] x, input logic [14:0] exp);
    @(negedge clk);
    pix_x = x;
    @(posedge clk);
    #1;
    check(tag, pix_color, exp);
  endtask

  initial begin
    rst_n      = 1'b0;
    dispcnt    = 16'h0;
    line_start = 1'b0;
    line_y     = 8'd0;
    pix_x      = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_req", vram_req, 0);
    check("rst_addr", vram_addr, 0);
    check("rst_pal", pal_addr, 0);
    check("rst_pix", pix_color, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Mode 3, line 5.
    a0 = acks;
    start_line(16'h0003, 8'd5);
    wait_req("m3_req");
    check("m3_first_addr", vram_addr, 1200);
    wait_idle("m3_done");
    check("m3_reads", acks - a0, 240);

    // Forced blank shows the mode-3 line.
    a0 = acks;
    start_line(16'h0083, 8'd0);
    expect_pix("m3_pix0", 8'd0, 15'd1200);
    expect_pix("m3_pix100", 8'd100, 15'd1300);
    expect_pix("m3_pix239", 8'd239, 15'd1439);
    expect_pix("m3_pix240", 8'd240, 15'd0);
    wait_idle("fb_done");
    check("fb_reads", acks - a0, 0);

    // Mode 4, page 1, line 0.
    a0 = acks;
    start_line(16'h0014, 8'd0);
    expect_pix("fb_pix0", 8'd0, 15'h7FFF);
    expect_pix("fb_pix239", 8'd239, 15'h7FFF);
    wait_req("m4_req");
    check("m4_first_addr", vram_addr, 16'h5000);
    wait_idle("m4_done");
    check("m4_reads", acks - a0, 120);

    // Mode 5, line 130: no VRAM traffic.
    a0 = req_cycles;
    start_line(16'h0005, 8'd130);
    expect_pix("m4_pix0", 8'd0, 15'h001F);
    expect_pix("m4_pix1", 8'd1, 15'h03E0);
    expect_pix("m4_pix3", 8'd3, 15'h4050);
    expect_pix("m4_pix4_idx0", 8'd4, 15'h1234);
    expect_pix("m4_pix5", 8'd5, 15'h4003);
    wait_idle("m5h_done");
    check("m5h_req_cycles", req_cycles - a0, 0);

    // Mode 5, line 0.
    a0 = acks;
    start_line(16'h0005, 8'd0);
    expect_pix("m5h_pix0", 8'd0, 15'h1234);
    expect_pix("m5h_pix239", 8'd239, 15'h1234);
    wait_idle("m5_done");
    check("m5_reads", acks - a0, 160);

    start_line(16'h0083, 8'd0);
    expect_pix("m5_pix1", 8'd1, 15'd1);
    expect_pix("m5_pix159", 8'd159, 15'd159);
    expect_pix("m5_pix160", 8'd160, 15'h1234);
    expect_pix("m5_pix239", 8'd239, 15'h1234);
    wait_idle("fb2_done");

    // Overrun: restart 50 cycles into a mode-3 fill.
    start_line(16'h0003, 8'd7);
    repeat (50) @(negedge clk);
    start_line(16'h0003, 8'd9);
    check("ovr_req_drop", vram_req, 0);
    check("ovr_set", overrun, 1);
    wait_req("ovr_req");
    check("ovr_first_addr", vram_addr, 2160);
    wait_idle("ovr_done");
    check("ovr_sticky", overrun, 1);
    start_line(16'h0083, 8'd0);
    expect_pix("ovr_pix0", 8'd0, 15'd2160);
    expect_pix("ovr_pix239", 8'd239, 15'd2399);
    wait_idle("fb3_done");
    check("ovr_sticky2", overrun, 1);
    expect_pix("ovr_pix5", 8'd5, 15'd2165);

    // Reset in the middle of a fill.
    start_line(16'h0003, 8'd3);
    wait_req("mid_req");
    check("pre_rst_pix", pix_color, 15'h7FFF);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", vram_req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pix", pix_color, 0);
    check("mid_rst_ovr", overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_line(16'h0003, 8'd2);
    wait_req("post_req");
    check("post_first_addr", vram_addr, 480);
    wait_idle("post_done");
    start_line(16'h0083, 8'd0);
    expect_pix("post_pix0", 8'd0, 15'd480);
    expect_pix("post_pix239", 8'd239, 15'd719);
    wait_idle("fb4_done");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
